// File: rtl/threshold_counter_pkg.sv
// Shared definitions for the threshold counter bank: the per-channel state
// encoding and the elaboration-time parameter legality check.
package threshold_counter_pkg;

    // Channel phase relative to the threshold and the terminal count.
    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,   // count <= THRESHOLD, delay not yet elapsed
        ST_HIGH = 2'd1,   // THRESHOLD < count < LIMIT
        ST_TERM = 2'd2    // count == LIMIT
    } state_t;

    // Returns 1 when the parameter set describes a buildable counter:
    //   - WIDTH is at least one bit and small enough to evaluate here;
    //   - THRESHOLD < LIMIT <= 2**WIDTH-1;
    //   - a zero threshold cannot be combined with wrap mode, because the
    //     wrap edge lands on 0 and the crossing edge would be ambiguous.
    function automatic bit params_legal(
        input int width,
        input int threshold,
        input int limit,
        input int wrap
    );
        longint max_count;
        bit     ok;
        ok = 1'b1;
        if (width < 1 || width > 31) begin
            ok = 1'b0;
        end else begin
            max_count = (longint'(1) << width) - 1;
            if (threshold < 0)                 ok = 1'b0;
            if (threshold >= limit)            ok = 1'b0;
            if (longint'(limit) > max_count)   ok = 1'b0;
            if (wrap != 0 && threshold == 0)   ok = 1'b0;
            if (wrap != 0 && wrap != 1)        ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/threshold_counter_ch.sv
// One enable-gated up-counter channel with a registered threshold level,
// a one-cycle crossing strobe and a terminal-count flag. In wrap mode the
// channel restarts from zero after the terminal count, so q_pulse becomes a
// divided tick with period LIMIT+1 enabled edges.
module threshold_counter_ch
    import threshold_counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int THRESHOLD = 3,
    parameter int LIMIT     = 7,
    parameter int WRAP      = 0
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             restart,
    output logic [WIDTH-1:0] count,
    output logic             q,
    output logic             q_pulse,
    output logic             at_limit
);

    // Refuse to build a counter whose threshold/limit cannot be reached.
    if (!params_legal(WIDTH, THRESHOLD, LIMIT, WRAP)) begin : g_bad_params
        $error("threshold_counter_ch: illegal WIDTH/THRESHOLD/LIMIT/WRAP combination");
    end

    localparam logic [WIDTH-1:0] THR_C     = WIDTH'(THRESHOLD);
    localparam logic [WIDTH-1:0] LIM_C     = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] PRE_LIM_C = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
    localparam bit               WRAP_EN   = (WRAP != 0);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             q_nxt;
    logic             pulse_nxt;
    logic             limit_nxt;

    // Next-state decode: restart beats enable, enable beats hold; the
    // strobe defaults low so it can never survive more than one edge.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        q_nxt     = q;
        pulse_nxt = 1'b0;
        limit_nxt = at_limit;

        if (restart) begin
            state_nxt = ST_LOW;
            count_nxt = '0;
            q_nxt     = 1'b0;
            limit_nxt = 1'b0;
        end else if (enable) begin
            unique case (state)
                ST_LOW: begin
                    count_nxt = count + ONE_C;
                    if (count == THR_C) begin
                        q_nxt     = 1'b1;
                        pulse_nxt = 1'b1;
                        // With LIMIT == THRESHOLD+1 the crossing edge is
                        // also the terminal edge, so HIGH is skipped.
                        if (THR_C == PRE_LIM_C) begin
                            state_nxt = ST_TERM;
                            limit_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    count_nxt = count + ONE_C;
                    if (count == PRE_LIM_C) begin
                        state_nxt = ST_TERM;
                        limit_nxt = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (WRAP_EN) begin
                        state_nxt = ST_LOW;
                        count_nxt = '0;
                        q_nxt     = 1'b0;
                        limit_nxt = 1'b0;
                    end else begin
                        // Saturated: sticky until restart or reset.
                        count_nxt = LIM_C;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean start.
                    state_nxt = ST_LOW;
                    count_nxt = '0;
                    q_nxt     = 1'b0;
                    limit_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; clear_n forces everything low at once.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ST_LOW;
            count    <= '0;
            q        <= 1'b0;
            q_pulse  <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            q        <= q_nxt;
            q_pulse  <= pulse_nxt;
            at_limit <= limit_nxt;
        end
    end

endmodule

// File: rtl/threshold_counter_bank.sv
// Bank of N_CH independent threshold counters providing power-on and step
// delays between the clock-divider tick and the controller FSM. Channels
// share only clock and clear_n; their outputs are packed into vectors with
// channel i at count[i*WIDTH +: WIDTH].
module threshold_counter_bank
    import threshold_counter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int WIDTH     = 3,
    parameter int THRESHOLD = 3,
    parameter int LIMIT     = 7,
    parameter int WRAP      = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [N_CH-1:0]       enable,
    input  logic [N_CH-1:0]       restart,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       q,
    output logic [N_CH-1:0]       q_pulse,
    output logic [N_CH-1:0]       at_limit
);

    // A bank with no channels is meaningless for the controller.
    if (N_CH < 1) begin : g_bad_nch
        $error("threshold_counter_bank: N_CH must be at least 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        threshold_counter_ch #(
            .WIDTH     (WIDTH),
            .THRESHOLD (THRESHOLD),
            .LIMIT     (LIMIT),
            .WRAP      (WRAP)
        ) u_ch (
            .clock    (clock),
            .clear_n  (clear_n),
            .enable   (enable[i]),
            .restart  (restart[i]),
            .count    (count[i*WIDTH +: WIDTH]),
            .q        (q[i]),
            .q_pulse  (q_pulse[i]),
            .at_limit (at_limit[i])
        );
    end

endmodule

// File: tb/tb_threshold_counter_bank.sv
// Directed bench for threshold_counter_bank: a saturating and a wrapping
// instance run side by side; every edge's expected outputs come from an
// arithmetic count model queued at drive time and checked after the edge,
// with literal spot checks at the documented latency points.
module tb_threshold_counter_bank;

    localparam int T = 3;
    localparam int L = 7;

    typedef struct {
        logic [5:0] cnt;
        logic [1:0] q;
        logic [1:0] qp;
        logic [1:0] al;
        logic [5:0] wcnt;
        logic [1:0] wq;
        logic [1:0] wqp;
        logic [1:0] wal;
    } exp_t;

    logic       clock;
    logic       clear_n;
    logic [1:0] enable, restart, wenable, wrestart;
    logic [5:0] count, wcount;
    logic [1:0] q, q_pulse, at_limit, wq, wq_pulse, wat_limit;

    int   compared;
    int   mismatched;
    int   mc[2];
    int   wc[2];
    exp_t sb[$];

    threshold_counter_bank dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .enable   (enable),
        .restart  (restart),
        .count    (count),
        .q        (q),
        .q_pulse  (q_pulse),
        .at_limit (at_limit)
    );

    threshold_counter_bank #(
        .N_CH(2), .WIDTH(3), .THRESHOLD(3), .LIMIT(7), .WRAP(1)
    ) dut_w (
        .clock    (clock),
        .clear_n  (clear_n),
        .enable   (wenable),
        .restart  (wrestart),
        .count    (wcount),
        .q        (wq),
        .q_pulse  (wq_pulse),
        .at_limit (wat_limit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        assert (act === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
        end
    endtask

    // Pop the oldest expectation and compare every output of both instances.
    task automatic check_out(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: scoreboard empty, observed count %0h", tag, count);
        end else begin
            x = sb.pop_front();
            chk({tag, ".count"},    32'(count),     32'(x.cnt));
            chk({tag, ".q"},        32'(q),         32'(x.q));
            chk({tag, ".q_pulse"},  32'(q_pulse),   32'(x.qp));
            chk({tag, ".at_limit"}, 32'(at_limit),  32'(x.al));
            chk({tag, ".wcount"},   32'(wcount),    32'(x.wcnt));
            chk({tag, ".wq"},       32'(wq),        32'(x.wq));
            chk({tag, ".wq_pulse"}, 32'(wq_pulse),  32'(x.wqp));
            chk({tag, ".wat_lim"},  32'(wat_limit), 32'(x.wal));
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, clock, check.
    task automatic step(input logic [1:0] e, input logic [1:0] r,
                        input logic [1:0] we, input logic [1:0] wr, input string tag);
        exp_t x;
        enable   = e;
        restart  = r;
        wenable  = we;
        wrestart = wr;
        for (int ch = 0; ch < 2; ch++) begin
            x.qp[ch] = !r[ch] && e[ch] && (mc[ch] == T);
            if (r[ch])      mc[ch] = 0;
            else if (e[ch]) mc[ch] = (mc[ch] == L) ? L : mc[ch] + 1;
            x.cnt[ch*3 +: 3] = 3'(mc[ch]);
            x.q[ch]  = (mc[ch] > T);
            x.al[ch] = (mc[ch] == L);

            x.wqp[ch] = !wr[ch] && we[ch] && (wc[ch] == T);
            if (wr[ch])      wc[ch] = 0;
            else if (we[ch]) wc[ch] = (wc[ch] == L) ? 0 : wc[ch] + 1;
            x.wcnt[ch*3 +: 3] = 3'(wc[ch]);
            x.wq[ch]  = (wc[ch] > T);
            x.wal[ch] = (wc[ch] == L);
        end
        sb.push_back(x);
        @(posedge clock);
        #1;
        check_out(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        mc = '{0, 0};
        wc = '{0, 0};
        enable   = 2'b00;
        restart  = 2'b00;
        wenable  = 2'b00;
        wrestart = 2'b00;
        clear_n  = 1'b1;

        // Reset state: asynchronous, visible without an edge.
        #1 clear_n = 1'b0;
        #2;
        chk("rst.count",    32'(count),     32'd0);
        chk("rst.q",        32'(q),         32'd0);
        chk("rst.q_pulse",  32'(q_pulse),   32'd0);
        chk("rst.at_limit", 32'(at_limit),  32'd0);
        chk("rst.wcount",   32'(wcount),    32'd0);
        @(posedge clock);
        #1 clear_n = 1'b1;

        // Scenario 1 + 6: ch0 counts continuously, ch1 is disturbed randomly.
        for (int k = 1; k <= 17; k++) begin
            logic [1:0] e, r;
            e = {1'($urandom_range(0, 1)), 1'b1};
            r = {1'($urandom_range(0, 3) == 0), 1'b0};
            step(e, r, 2'b00, 2'b00, "s1");
            if (k == 4) begin
                chk("s1.e4.count", 32'(count[2:0]), 32'd4);
                chk("s1.e4.q",     32'(q[0]),       32'd1);
                chk("s1.e4.pulse", 32'(q_pulse[0]), 32'd1);
            end
            if (k == 5) chk("s1.e5.pulse", 32'(q_pulse[0]), 32'd0);
            if (k == 6) chk("s1.e6.limit", 32'(at_limit[0]), 32'd0);
            if (k >= 7) begin
                chk("s1.sat.count", 32'(count[2:0]),  32'd7);
                chk("s1.sat.limit", 32'(at_limit[0]), 32'd1);
                chk("s1.sat.pulse", 32'(q_pulse[0]),  32'd0);
            end
        end

        // Scenario 2: enable gap holds the count.
        step(2'b00, 2'b11, 2'b00, 2'b00, "s2.rs");
        step(2'b11, 2'b00, 2'b00, 2'b00, "s2.a");
        step(2'b11, 2'b00, 2'b00, 2'b00, "s2.b");
        for (int k = 0; k < 5; k++) begin
            step(2'b00, 2'b00, 2'b00, 2'b00, "s2.gap");
            chk("s2.gap.count", 32'(count[2:0]), 32'd2);
        end
        step(2'b11, 2'b00, 2'b00, 2'b00, "s2.c");
        chk("s2.c.q", 32'(q[0]), 32'd0);
        step(2'b11, 2'b00, 2'b00, 2'b00, "s2.d");
        chk("s2.d.count", 32'(count[2:0]), 32'd4);
        chk("s2.d.q",     32'(q[0]),       32'd1);

        // Scenario 3: restart wins over enable.
        step(2'b01, 2'b00, 2'b00, 2'b00, "s3.to5");
        chk("s3.at5", 32'(count[2:0]), 32'd5);
        step(2'b01, 2'b01, 2'b00, 2'b00, "s3.rs");
        chk("s3.rs.count", 32'(count[2:0]), 32'd0);
        chk("s3.rs.q",     32'(q[0]),       32'd0);
        chk("s3.rs.pulse", 32'(q_pulse[0]), 32'd0);
        step(2'b01, 2'b00, 2'b00, 2'b00, "s3.c1");
        chk("s3.c1", 32'(count[2:0]), 32'd1);
        step(2'b01, 2'b00, 2'b00, 2'b00, "s3.c2");
        chk("s3.c2", 32'(count[2:0]), 32'd2);

        // Scenario 4: clear_n dropped mid-count between edges.
        for (int k = 0; k < 4; k++) step(2'b01, 2'b00, 2'b01, 2'b00, "s4.run");
        chk("s4.at6", 32'(count[2:0]), 32'd6);
        #2 clear_n = 1'b0;
        #1;
        chk("s4.clr.count", 32'(count),     32'd0);
        chk("s4.clr.q",     32'(q),         32'd0);
        chk("s4.clr.limit", 32'(at_limit),  32'd0);
        chk("s4.clr.wcnt",  32'(wcount),    32'd0);
        mc = '{0, 0};
        wc = '{0, 0};
        @(posedge clock);
        #1 clear_n = 1'b1;
        step(2'b01, 2'b00, 2'b00, 2'b00, "s4.r1");
        chk("s4.r1", 32'(count[2:0]), 32'd1);
        step(2'b01, 2'b00, 2'b00, 2'b00, "s4.r2");
        chk("s4.r2", 32'(count[2:0]), 32'd2);

        // Scenario 5: wrap instance as a divide-by-8 tick.
        step(2'b00, 2'b00, 2'b00, 2'b11, "s5.rs");
        for (int k = 1; k <= 20; k++) begin
            step(2'b00, 2'b00, 2'b11, 2'b00, "s5");
            chk("s5.count", 32'(wcount[2:0]),  32'(k % 8));
            chk("s5.pulse", 32'(wq_pulse[0]),  32'((k % 8) == 4));
            chk("s5.q",     32'(wq[0]),        32'((k % 8) >= 4));
            chk("s5.limit", 32'(wat_limit[0]), 32'((k % 8) == 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
